// File: rtl/trigger_pkg.sv
// Shared types and default parameters for the push-button trigger conditioner.
package trigger_pkg;

    typedef enum logic [1:0] {
        T_IDLE,
        T_PRESS_WAIT,
        T_PRESSED,
        T_RELEASE_WAIT
    } trig_state_t;

    localparam int unsigned DEF_SYNC_STAGES     = 2;
    localparam int unsigned DEF_DEBOUNCE_CYCLES = 16;
    localparam int unsigned DEF_COUNT_WIDTH     = 8;

endpackage

// File: rtl/sync_chain.sv
// Multi-flop synchroniser for an asynchronous single-bit board input.
module sync_chain #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr <= '0;
        end else begin
            sr <= {sr[STAGES-2:0], d};
        end
    end

    assign q = sr[STAGES-1];

endmodule

// File: rtl/trigger_conditioner.sv
// Synchronises and debounces the raw push-button on both edges; emits a clean
// level, a one-cycle press pulse and a wrapping press counter.
module trigger_conditioner
    import trigger_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned COUNT_WIDTH     = DEF_COUNT_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   trigger_raw_i,
    output logic                   trigger_o,
    output logic                   trigger_pulse_o,
    output logic [COUNT_WIDTH-1:0] press_count_o
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1) begin : g_bad_params
        $error("trigger_conditioner: SYNC_STAGES must be >= 2 and DEBOUNCE_CYCLES >= 1");
    end

    logic        btn_sync;
    trig_state_t state;
    logic [CNT_W-1:0] cnt;

    sync_chain #(
        .STAGES(SYNC_STAGES)
    ) u_sync (
        .clk(clk),
        .rst(rst),
        .d  (trigger_raw_i),
        .q  (btn_sync)
    );

    // Debounce FSM; cnt counts consecutive stable cycles inside the WAIT states.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= T_IDLE;
            cnt             <= '0;
            trigger_o       <= 1'b0;
            trigger_pulse_o <= 1'b0;
            press_count_o   <= '0;
        end else begin
            trigger_pulse_o <= 1'b0;
            case (state)
                T_IDLE: begin
                    if (btn_sync) begin
                        state <= T_PRESS_WAIT;
                        cnt   <= '0;
                    end
                end
                T_PRESS_WAIT: begin
                    if (!btn_sync) begin
                        state <= T_IDLE;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state           <= T_PRESSED;
                        cnt             <= '0;
                        trigger_o       <= 1'b1;
                        trigger_pulse_o <= 1'b1;
                        press_count_o   <= press_count_o + COUNT_WIDTH'(1);
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                T_PRESSED: begin
                    if (!btn_sync) begin
                        state <= T_RELEASE_WAIT;
                        cnt   <= '0;
                    end
                end
                T_RELEASE_WAIT: begin
                    if (btn_sync) begin
                        state <= T_PRESSED;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state     <= T_IDLE;
                        cnt       <= '0;
                        trigger_o <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= T_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_trigger_conditioner.sv
// Directed bench for trigger_conditioner: default instance plus a minimum-parameter instance.
module tb_trigger_conditioner;
    import trigger_pkg::*;

    logic       clk;
    logic       rst;
    logic       raw;
    logic       raw_min;
    logic       trig;
    logic       pulse;
    logic [7:0] count;
    logic       trig_min;
    logic       pulse_min;
    logic [3:0] count_min;

    int checks;
    int errors;
    int pulses;
    int pulses_min;

    trigger_conditioner dut (
        .clk            (clk),
        .rst            (rst),
        .trigger_raw_i  (raw),
        .trigger_o      (trig),
        .trigger_pulse_o(pulse),
        .press_count_o  (count)
    );

    trigger_conditioner #(
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(1),
        .COUNT_WIDTH    (4)
    ) dut_min (
        .clk            (clk),
        .rst            (rst),
        .trigger_raw_i  (raw_min),
        .trigger_o      (trig_min),
        .trigger_pulse_o(pulse_min),
        .press_count_o  (count_min)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (pulse)     pulses     <= pulses + 1;
        if (pulse_min) pulses_min <= pulses_min + 1;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step(2);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        raw = 1'b0;
        raw_min = 1'b0;
        do_reset();
        step(1);
        checks++;
        if (trig !== 1'b0 || pulse !== 1'b0 || count !== 8'd0) begin
            errors++;
            $display("FAIL reset_outputs: trig=%b pulse=%b count=%0d expected 0 0 0", trig, pulse, count);
        end
        checks++;
        if (dut.state !== T_IDLE) begin
            errors++;
            $display("FAIL reset_state: state=%0d expected %0d", dut.state, T_IDLE);
        end
    endtask

    task automatic test_clean_press();
        int p0;
        p0 = pulses;
        raw = 1'b1;
        step(18);
        checks++;
        if (trig !== 1'b0) begin
            errors++;
            $display("FAIL press_edge18: trig=%b expected 0", trig);
        end
        step(1);
        checks++;
        if (trig !== 1'b1 || pulse !== 1'b1 || count !== 8'd1) begin
            errors++;
            $display("FAIL press_edge19: trig=%b pulse=%b count=%0d expected 1 1 1", trig, pulse, count);
        end
        step(1);
        checks++;
        if (pulse !== 1'b0) begin
            errors++;
            $display("FAIL pulse_fall: pulse=%b expected 0", pulse);
        end
        step(20);
        checks++;
        if (trig !== 1'b1 || pulses - p0 !== 1) begin
            errors++;
            $display("FAIL press_hold: trig=%b pulses=%0d expected 1 1", trig, pulses - p0);
        end
        raw = 1'b0;
        step(18);
        checks++;
        if (trig !== 1'b1) begin
            errors++;
            $display("FAIL release_edge18: trig=%b expected 1", trig);
        end
        step(1);
        checks++;
        if (trig !== 1'b0 || count !== 8'd1) begin
            errors++;
            $display("FAIL release_edge19: trig=%b count=%0d expected 0 1", trig, count);
        end
    endtask

    task automatic test_press_glitch();
        int p0;
        p0 = pulses;
        raw = 1'b1;
        step(10);
        raw = 1'b0;
        step(30);
        checks++;
        if (trig !== 1'b0 || count !== 8'd1 || pulses - p0 !== 0) begin
            errors++;
            $display("FAIL press_glitch: trig=%b count=%0d pulses=%0d expected 0 1 0", trig, count, pulses - p0);
        end
        checks++;
        if (dut.state !== T_IDLE) begin
            errors++;
            $display("FAIL glitch_state: state=%0d expected %0d", dut.state, T_IDLE);
        end
    endtask

    task automatic test_release_bounce();
        int p0;
        p0 = pulses;
        raw = 1'b1;
        step(25);
        raw = 1'b0;
        step(5);
        raw = 1'b1;
        step(3);
        raw = 1'b0;
        step(18);
        checks++;
        if (trig !== 1'b1) begin
            errors++;
            $display("FAIL bounce_edge18: trig=%b expected 1", trig);
        end
        step(1);
        checks++;
        if (trig !== 1'b0 || count !== 8'd2 || pulses - p0 !== 1) begin
            errors++;
            $display("FAIL bounce_edge19: trig=%b count=%0d pulses=%0d expected 0 2 1", trig, count, pulses - p0);
        end
    endtask

    task automatic test_reset_mid_press();
        int p0;
        raw = 1'b1;
        step(15);
        checks++;
        if (dut.state !== T_PRESS_WAIT || trig !== 1'b0) begin
            errors++;
            $display("FAIL midpress_state: state=%0d trig=%b expected %0d 0", dut.state, trig, T_PRESS_WAIT);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (trig !== 1'b0 || pulse !== 1'b0 || count !== 8'd0) begin
            errors++;
            $display("FAIL midpress_reset: trig=%b pulse=%b count=%0d expected 0 0 0", trig, pulse, count);
        end
        step(2);
        p0 = pulses;
        rst = 1'b1;
        step(18);
        checks++;
        if (trig !== 1'b0 || pulses - p0 !== 0) begin
            errors++;
            $display("FAIL midpress_edge18: trig=%b pulses=%0d expected 0 0", trig, pulses - p0);
        end
        step(1);
        checks++;
        if (trig !== 1'b1 || pulse !== 1'b1 || count !== 8'd1) begin
            errors++;
            $display("FAIL midpress_edge19: trig=%b pulse=%b count=%0d expected 1 1 1", trig, pulse, count);
        end
        raw = 1'b0;
        step(22);
        checks++;
        if (trig !== 1'b0 || pulses - p0 !== 1) begin
            errors++;
            $display("FAIL midpress_after: trig=%b pulses=%0d expected 0 1", trig, pulses - p0);
        end
    endtask

    task automatic press_once();
        raw = 1'b1;
        step(21);
        raw = 1'b0;
        step(21);
    endtask

    task automatic test_counter_wrap();
        int p0;
        do_reset();
        step(1);
        p0 = pulses;
        for (int i = 0; i < 255; i++) press_once();
        checks++;
        if (count !== 8'd255) begin
            errors++;
            $display("FAIL wrap_255: count=%0d expected 255", count);
        end
        press_once();
        checks++;
        if (count !== 8'd0 || pulses - p0 !== 256) begin
            errors++;
            $display("FAIL wrap_0: count=%0d pulses=%0d expected 0 256", count, pulses - p0);
        end
    endtask

    task automatic test_min_params();
        int p0;
        do_reset();
        step(1);
        p0 = pulses_min;
        raw_min = 1'b1;
        step(3);
        checks++;
        if (trig_min !== 1'b0) begin
            errors++;
            $display("FAIL min_edge3: trig=%b expected 0", trig_min);
        end
        step(1);
        checks++;
        if (trig_min !== 1'b1 || pulse_min !== 1'b1 || count_min !== 4'd1) begin
            errors++;
            $display("FAIL min_edge4: trig=%b pulse=%b count=%0d expected 1 1 1", trig_min, pulse_min, count_min);
        end
        raw_min = 1'b0;
        step(8);
        checks++;
        if (trig_min !== 1'b0) begin
            errors++;
            $display("FAIL min_release: trig=%b expected 0", trig_min);
        end
        raw_min = 1'b1;
        step(1);
        raw_min = 1'b0;
        step(8);
        checks++;
        if (trig_min !== 1'b0 || count_min !== 4'd1 || pulses_min - p0 !== 1) begin
            errors++;
            $display("FAIL min_glitch: trig=%b count=%0d pulses=%0d expected 0 1 1", trig_min, count_min, pulses_min - p0);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        pulses = 0;
        pulses_min = 0;
        rst = 1'b1;
        raw = 1'b0;
        raw_min = 1'b0;
        test_reset();
        test_clean_press();
        test_press_glitch();
        test_release_bounce();
        test_reset_mid_press();
        test_counter_wrap();
        test_min_params();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
